// File: rtl/tt_um_fa_tester.sv
// Stimulus/checker for an external 1-bit full adder: walks all eight {cin,b,a}
// vectors on uio, waits a programmable settle time, and scores the sum/cout return.
module tt_um_fa_tester (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t     state;
    logic [2:0] vec;
    logic [3:0] wcnt;
    logic [3:0] s_lat;
    logic       loop_lat;
    logic [3:0] err_cnt;
    logic [2:0] first_fail;
    logic       fseen;
    logic       run_done;

    logic       start;
    logic [3:0] settle;
    logic [1:0] expected;
    logic [1:0] returned;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic       unused_bits;

    assign start    = ui_in[0];
    assign settle   = ui_in[4:1];
    assign returned = uio_in[4:3];
    assign expected = {1'b0, vec[0]} + {1'b0, vec[1]} + {1'b0, vec[2]};

    assign unused_bits = &{1'b0, ui_in[7:6], uio_in[7:5], uio_in[2:0]};

    // The external DUT is sampled raw on the last edge of each vector's window,
    // so the error update and the move to the next vector share that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec        <= 3'd0;
            wcnt       <= 4'd0;
            s_lat      <= 4'd0;
            loop_lat   <= 1'b0;
            err_cnt    <= 4'd0;
            first_fail <= 3'd0;
            fseen      <= 1'b0;
            run_done   <= 1'b0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_WAIT;
                        vec        <= 3'd0;
                        wcnt       <= settle;
                        s_lat      <= settle;
                        loop_lat   <= ui_in[5];
                        err_cnt    <= 4'd0;
                        first_fail <= 3'd0;
                        fseen      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        if (returned != expected) begin
                            if (err_cnt != 4'hF)
                                err_cnt <= err_cnt + 4'd1;
                            if (!fseen) begin
                                first_fail <= vec;
                                fseen      <= 1'b1;
                            end
                        end
                        if (vec != 3'd7) begin
                            vec  <= vec + 3'd1;
                            wcnt <= s_lat;
                        end else begin
                            state    <= ST_DONE;
                            run_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Loop mode keeps E/F/fseen so errors accumulate across passes.
                    if (loop_lat) begin
                        state <= ST_WAIT;
                        vec   <= 3'd0;
                        wcnt  <= s_lat;
                    end else if (!start) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_WAIT);
    assign done = (state == ST_DONE) || ((state == ST_IDLE) && run_done);
    assign pass = done && (err_cnt == 4'd0);
    assign fail = done && (err_cnt != 4'd0);

    assign uo_out  = {err_cnt, fail, pass, done, busy};
    assign uio_out = {first_fail, 2'b00, (busy ? vec : 3'd0)};
    assign uio_oe  = 8'hE7;

endmodule

// File: doc/tt_um_fa_tester.md
# tt_um_fa_tester

Tiny Tapeout user project that acts as the stimulus and checking end for an external 1-bit full-adder device under test. It drives all eight {cin,b,a} input vectors onto the bidirectional pins and waits a programmable settle time per vector. It then samples the DUT's sum/carry return pins and compares them against the expected full-adder result. Pass/fail, error count and first failing vector are reported on the dedicated outputs. The block is the companion tester for our gate/full-adder delay experiments.

## Interface

- No parameters.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  design enable; when low, all state holds.
- ui_in  input  8  [0] start (level), [4:1] settle count S (0..15), [5] loop mode, [7:6] unused.
- uo_out  output  8  [0] busy, [1] done, [2] pass, [3] fail, [7:4] error count E.
- uio_in  input  8  [3] DUT sum, [4] DUT cout; other bits ignored.
- uio_out  output  8  [0] a, [1] b, [2] cin, [4:3] 0, [7:5] first failing vector F.
- uio_oe  output  8  constant 8'b1110_0111.

## Operation

- States: IDLE, WAIT, DONE.
- Registers:
  - vec: 3-bit vector index.
  - wcnt: 4-bit settle counter.
  - s_lat: latched S.
  - loop_lat: latched loop mode.
  - E: 4-bit error count, saturating at 15.
  - F: 3-bit first failing vector.
  - fseen: set once F has been captured.
- IDLE, on start=1:
  - Go to WAIT.
  - vec=0, wcnt=S, s_lat=S, loop_lat=ui_in[5].
  - E=0, fseen=0, F=0.
- WAIT:
  - uio_out[2:0]=vec.
  - If wcnt≠0, decrement wcnt.
  - If wcnt==0, sample {cout,sum}=uio_in[4:3] and compare against expected {cout,sum} = a+b+cin, 2-bit.
  - On mismatch: E=min(E+1,15). If fseen=0, set F=vec and fseen=1.
  - If vec<7: vec+1, wcnt=s_lat, stay in WAIT.
  - If vec==7: go to DONE.
- DONE:
  - If loop_lat=1: next cycle go to WAIT with vec=0, wcnt=s_lat. E, F and fseen are kept, so E accumulates across passes.
  - If loop_lat=0: go to IDLE only once start=0. Holding start high keeps the block in DONE, so there is no retrigger.
- Start is ignored in WAIT and DONE.
- uio_out[2:0]=0 in IDLE and DONE.
- Status outputs:
  - busy = (state==WAIT).
  - done = (state==DONE), or (state==IDLE and a run has completed since reset).
  - pass = done & (E==0).
  - fail = done & (E≠0).
  - E and F are held in IDLE until the next start clears them.
- ena=0: no register updates, outputs hold.
- Unused ui_in bits are ignored.

## Timing

- Reset (async assert, any state, including mid-run):
  - state=IDLE.
  - uo_out=0, uio_out=0, and the completed-run flag is cleared.
  - uio_oe=8'hE7 at all times.
  - Registers are released on the first clk edge after rst_n rises.
- Run timing:
  - Start is sampled at edge 0, and vec 0 is driven from edge 0.
  - Each vector occupies exactly S+1 cycles.
  - The sample is taken at the last edge of each vector.
  - DONE is entered at edge 8·(S+1).
- Loop mode: the first vector of the next pass is driven one cycle after DONE is entered. Each pass is 8·(S+1)+1 cycles.
- uio_in is sampled directly with no synchronizer. The external DUT path must settle within S+1 cycles.
- The E update and the state transition occur at the same edge. done/pass/fail are valid in the first DONE cycle.

## Test plan

- Correct behavioural full-adder on uio, S=0, start pulsed → busy for 8 cycles, vectors 0..7 appear, then done=1, pass=1, E=0.
- Correct DUT, S=3 → each vector held 4 cycles, done at cycle 32, pass=1.
- Sum stuck-at-0, S=0 → E=4 (vectors 1,2,4,7), F=1, fail=1, pass=0.
- Cout stuck-at-1, loop mode, S=0 → 4 errors per pass (vectors 0,1,2,4). After pass 4 E=15, and it stays 15 on later passes. F=0.
- Assert rst_n low at cycle 5 of an S=1 run → uo_out=0 and uio_out=0 immediately. After release, no activity until a new start.
- ena=0 for 10 cycles mid-run → vec, wcnt and E are frozen. After ena=1 the run completes with the same result and timing, shifted by 10 cycles.
- Hold start high after completion → DONE persists with no second run. Drop start, then raise it → a new run starts and E and F are cleared.
